// File: rtl/datapath_exec.sv
// Execute/write-back sequencer behind the 8x16 regfile: read A, read B, ALU, write C, pulse done.
// Optional build macro STATUS_NV_EN adds the N (result msb) and V (signed overflow) status flags.
//
// state | meaning
// IDLE  | waiting for start; op fields latched when start is seen
// RDA   | rf_readnum = rn_a, A captured from rf_data_out
// RDB   | rf_readnum = rn_b, B captured from rf_data_out
// EXEC  | operand select / shift / ALU, C and flags latched
// WB    | rf_writenum = rd, rf_write = 1, regfile captures C
// DONE  | done pulses for one cycle
module datapath_exec #(
  parameter int WIDTH    = 16,
  parameter int REGNUM_W = 3,
  parameter int IMM_W    = 5
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [REGNUM_W-1:0] rn_a,
  input  logic [REGNUM_W-1:0] rn_b,
  input  logic [REGNUM_W-1:0] rd,
  input  logic [1:0]          shift,
  input  logic [1:0]          alu_op,
  input  logic                asel,
  input  logic                bsel,
  input  logic [IMM_W-1:0]    imm,
  input  logic [WIDTH-1:0]    rf_data_out,
  output logic [REGNUM_W-1:0] rf_readnum,
  output logic [REGNUM_W-1:0] rf_writenum,
  output logic                rf_write,
  output logic [WIDTH-1:0]    rf_data_in,
  output logic                busy,
  output logic                done,
  output logic                status_z,
  output logic                status_n,
  output logic                status_v
);

  typedef enum logic [2:0] {
    S_IDLE, S_RDA, S_RDB, S_EXEC, S_WB, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [REGNUM_W-1:0] rn_a_q, rn_a_d, rn_b_q, rn_b_d, rd_q, rd_d;
  logic [1:0]          shift_q, shift_d, alu_op_q, alu_op_d;
  logic                asel_q, asel_d, bsel_q, bsel_d;
  logic [IMM_W-1:0]    imm_q, imm_d;
  logic [WIDTH-1:0]    a_q, a_d, b_q, b_d, c_q, c_d;
  logic                z_q, z_d;
  logic [REGNUM_W-1:0] readnum_q, readnum_d, writenum_q, writenum_d;

  logic [WIDTH-1:0] b_shift, b_op, a_op, alu_res;

  always_comb begin
    case (shift_q)
      2'b01:   b_shift = {b_q[WIDTH-2:0], 1'b0};
      2'b10:   b_shift = {1'b0, b_q[WIDTH-1:1]};
      2'b11:   b_shift = {b_q[WIDTH-1], b_q[WIDTH-1:1]};
      default: b_shift = b_q;
    endcase
    b_op = bsel_q ? {{(WIDTH-IMM_W){1'b0}}, imm_q} : b_shift;
    a_op = asel_q ? '0 : a_q;
    case (alu_op_q)
      2'b00:   alu_res = a_op + b_op;
      2'b01:   alu_res = a_op - b_op;
      2'b10:   alu_res = a_op & b_op;
      default: alu_res = ~b_op;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    rn_a_d      = rn_a_q;
    rn_b_d      = rn_b_q;
    rd_d        = rd_q;
    shift_d     = shift_q;
    alu_op_d    = alu_op_q;
    asel_d      = asel_q;
    bsel_d      = bsel_q;
    imm_d       = imm_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    z_d         = z_q;
    rf_readnum  = readnum_q;
    rf_writenum = writenum_q;
    rf_write    = 1'b0;
    done        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          rn_a_d   = rn_a;
          rn_b_d   = rn_b;
          rd_d     = rd;
          shift_d  = shift;
          alu_op_d = alu_op;
          asel_d   = asel;
          bsel_d   = bsel;
          imm_d    = imm;
          state_d  = S_RDA;
        end
      end
      S_RDA: begin
        rf_readnum = rn_a_q;
        a_d        = rf_data_out;
        state_d    = S_RDB;
      end
      S_RDB: begin
        rf_readnum = rn_b_q;
        b_d        = rf_data_out;
        state_d    = S_EXEC;
      end
      S_EXEC: begin
        c_d     = alu_res;
        z_d     = (alu_res == '0);
        state_d = S_WB;
      end
      S_WB: begin
        rf_writenum = rd_q;
        // a reset landing on the WB edge must not let the regfile capture C
        rf_write    = reset_n;
        state_d     = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    readnum_d  = rf_readnum;
    writenum_d = rf_writenum;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      rn_a_q     <= '0;
      rn_b_q     <= '0;
      rd_q       <= '0;
      shift_q    <= '0;
      alu_op_q   <= '0;
      asel_q     <= 1'b0;
      bsel_q     <= 1'b0;
      imm_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      z_q        <= 1'b0;
      readnum_q  <= '0;
      writenum_q <= '0;
    end else begin
      state_q    <= state_d;
      rn_a_q     <= rn_a_d;
      rn_b_q     <= rn_b_d;
      rd_q       <= rd_d;
      shift_q    <= shift_d;
      alu_op_q   <= alu_op_d;
      asel_q     <= asel_d;
      bsel_q     <= bsel_d;
      imm_q      <= imm_d;
      a_q        <= a_d;
      b_q        <= b_d;
      c_q        <= c_d;
      z_q        <= z_d;
      readnum_q  <= readnum_d;
      writenum_q <= writenum_d;
    end
  end

  assign rf_data_in = c_q;
  assign busy       = (state_q != S_IDLE);
  assign status_z   = z_q;

`ifdef STATUS_NV_EN
  logic ovf, v_q, v_d;

  always_comb begin
    ovf = 1'b0;
    if (alu_op_q == 2'b00)
      ovf = (a_op[WIDTH-1] == b_op[WIDTH-1]) && (alu_res[WIDTH-1] != a_op[WIDTH-1]);
    else if (alu_op_q == 2'b01)
      ovf = (a_op[WIDTH-1] != b_op[WIDTH-1]) && (alu_res[WIDTH-1] != a_op[WIDTH-1]);
    v_d = v_q;
    if (state_q == S_EXEC) v_d = ovf;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) v_q <= 1'b0;
    else          v_q <= v_d;
  end

  // C only changes in EXEC, so its msb already behaves as a latched flag
  assign status_n = c_q[WIDTH-1];
  assign status_v = v_q;
`else
  assign status_n = 1'b0;
  assign status_v = 1'b0;
`endif

endmodule

// File: tb/tb_datapath_exec.sv
// Bench for datapath_exec: behavioural 8x16 regfile, directed scenarios and randomized ops
// checked against an arithmetic reference model.
module tb_datapath_exec;

  logic        clk = 1'b0;
  logic        reset_n, start;
  logic [2:0]  rn_a, rn_b, rd;
  logic [1:0]  shift, alu_op;
  logic        asel, bsel;
  logic [4:0]  imm;
  logic [15:0] rf_data_out;
  logic [2:0]  rf_readnum, rf_writenum;
  logic        rf_write;
  logic [15:0] rf_data_in;
  logic        busy, done, status_z, status_n, status_v;

  datapath_exec dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .rn_a(rn_a), .rn_b(rn_b), .rd(rd), .shift(shift), .alu_op(alu_op),
    .asel(asel), .bsel(bsel), .imm(imm), .rf_data_out(rf_data_out),
    .rf_readnum(rf_readnum), .rf_writenum(rf_writenum), .rf_write(rf_write),
    .rf_data_in(rf_data_in), .busy(busy), .done(done),
    .status_z(status_z), .status_n(status_n), .status_v(status_v)
  );

  always #5 clk = ~clk;

  logic [15:0] rf [8];
  logic        pl_en = 1'b0;
  logic [2:0]  pl_addr = '0;
  logic [15:0] pl_data = '0;
  int          write_count = 0;

  assign rf_data_out = rf[rf_readnum];

  always @(posedge clk) begin
    if (pl_en) rf[pl_addr] <= pl_data;
    else if (rf_write) rf[rf_writenum] <= rf_data_in;
    if (rf_write) write_count <= write_count + 1;
  end

  int total = 0;
  int bad   = 0;
  int de, nw;
  logic [2:0] wa;
  bit bok;
  logic [15:0] model_rf [8];

`ifdef STATUS_NV_EN
  localparam bit NV_EN = 1'b1;
`else
  localparam bit NV_EN = 1'b0;
`endif

  function automatic void ref_exec(input int a, input int b, input int sh, input int op,
                                   input int as, input int bs, input int im,
                                   output int c, output bit z, output bit n, output bit v);
    int ao, bo, sa, sb, r;
    case (sh)
      1:       bo = (b * 2) % 65536;
      2:       bo = b / 2;
      3:       bo = b / 2 + ((b >= 32768) ? 32768 : 0);
      default: bo = b;
    endcase
    if (bs != 0) bo = im;
    ao = (as != 0) ? 0 : a;
    case (op)
      0:       c = (ao + bo) % 65536;
      1:       c = (ao - bo + 65536) % 65536;
      2:       c = ao & bo;
      default: c = 65535 - bo;
    endcase
    sa = (ao >= 32768) ? ao - 65536 : ao;
    sb = (bo >= 32768) ? bo - 65536 : bo;
    r  = (op == 0) ? sa + sb : sa - sb;
    v  = (op <= 1) && (r > 32767 || r < -32768);
    z  = (c == 0);
    n  = (c >= 32768);
  endfunction

  task automatic preload(input logic [2:0] addr, input logic [15:0] val);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = addr; pl_data = val;
    @(posedge clk);
    #1 pl_en = 1'b0;
    model_rf[addr] = val;
  endtask

  // Drives one op, scrambles the input pins while busy, and records what it sees.
  task automatic issue_op(input logic [2:0] ra, input logic [2:0] rb, input logic [2:0] rdd,
                          input logic [1:0] sh, input logic [1:0] op, input logic as,
                          input logic bs, input logic [4:0] im, input int pulse_at,
                          input logic [2:0] alt_rd, output int o_de, output int o_nw,
                          output logic [2:0] o_wa, output bit o_bok);
    @(negedge clk);
    rn_a = ra; rn_b = rb; rd = rdd; shift = sh; alu_op = op;
    asel = as; bsel = bs; imm = im; start = 1'b1;
    o_de = -1; o_nw = 0; o_wa = '0; o_bok = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      rn_a = 3'($urandom); rn_b = 3'($urandom); rd = 3'($urandom);
      shift = 2'($urandom); alu_op = 2'($urandom);
      asel = 1'($urandom); bsel = 1'($urandom); imm = 5'($urandom);
      if (k == pulse_at) begin start = 1'b1; rd = alt_rd; end
      if (rf_write) begin o_nw++; o_wa = rf_writenum; end
      if (!busy) o_bok = 1'b0;
      if (done) begin o_de = k; break; end
    end
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; start = 1'b0; rn_a = '0; rn_b = '0; rd = '0;
    shift = '0; alu_op = '0; asel = 1'b0; bsel = 1'b0; imm = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({busy, done, rf_write, status_z, status_n, status_v} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got %b want 000000", {busy, done, rf_write, status_z, status_n, status_v});
    end
    total++;
    if ({rf_readnum, rf_writenum, rf_data_in} !== 22'd0) begin
      bad++;
      $display("FAIL reset_data: got rn=%0d wn=%0d din=%h want 0 0 0000", rf_readnum, rf_writenum, rf_data_in);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) preload(3'(i), 16'(i * 16'h0101));
    preload(3'd0, 16'd3);
    preload(3'd1, 16'd320);
  endtask

  task automatic test_add;
    issue_op(3'd0, 3'd1, 3'd2, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0, -1, 3'd0, de, nw, wa, bok);
    total++;
    if (de !== 4) begin bad++; $display("FAIL add_latency: got done at edge %0d want 4", de); end
    total++;
    if (rf[2] !== 16'd323) begin bad++; $display("FAIL add_result: got %0d want 323", rf[2]); end
    total++;
    if (status_z !== 1'b0) begin bad++; $display("FAIL add_z: got %b want 0", status_z); end
    total++;
    if (nw !== 1 || wa !== 3'd2 || bok !== 1'b1) begin
      bad++; $display("FAIL add_wb: got writes=%0d addr=%0d busy_ok=%0d want 1 2 1", nw, wa, bok);
    end
    total++;
    if (busy !== 1'b0 || rf_readnum !== 3'd1 || rf_writenum !== 3'd2) begin
      bad++; $display("FAIL add_idle_hold: got busy=%b rn=%0d wn=%0d want 0 1 2", busy, rf_readnum, rf_writenum);
    end
    model_rf[2] = 16'd323;
  endtask

  task automatic test_sub_shift;
    issue_op(3'd1, 3'd0, 3'd3, 2'b01, 2'b01, 1'b0, 1'b0, 5'd0, -1, 3'd0, de, nw, wa, bok);
    total++;
    if (rf[3] !== 16'd314) begin bad++; $display("FAIL sub_lsl: got %0d want 314", rf[3]); end
    preload(3'd7, 16'h8006);
    issue_op(3'd1, 3'd7, 3'd3, 2'b11, 2'b01, 1'b0, 1'b0, 5'd0, -1, 3'd0, de, nw, wa, bok);
    total++;
    if (rf[3] !== 16'h413D) begin bad++; $display("FAIL sub_asr: got %h want 413d", rf[3]); end
    issue_op(3'd1, 3'd7, 3'd5, 2'b10, 2'b00, 1'b1, 1'b0, 5'd0, -1, 3'd0, de, nw, wa, bok);
    total++;
    if (rf[5] !== 16'h4003) begin bad++; $display("FAIL add_lsr: got %h want 4003", rf[5]); end
    model_rf[3] = 16'h413D; model_rf[5] = 16'h4003;
  endtask

  task automatic test_zero_imm;
    issue_op(3'd0, 3'd0, 3'd4, 2'b00, 2'b01, 1'b0, 1'b0, 5'd0, -1, 3'd0, de, nw, wa, bok);
    total++;
    if (rf[4] !== 16'd0 || status_z !== 1'b1) begin
      bad++; $display("FAIL sub_zero: got r4=%0d z=%b want 0 1", rf[4], status_z);
    end
    issue_op(3'd1, 3'd2, 3'd4, 2'b00, 2'b00, 1'b1, 1'b1, 5'd5, -1, 3'd0, de, nw, wa, bok);
    total++;
    if (rf[4] !== 16'd5 || status_z !== 1'b0) begin
      bad++; $display("FAIL imm_add: got r4=%0d z=%b want 5 0", rf[4], status_z);
    end
    model_rf[4] = 16'd5;
  endtask

  task automatic test_overflow;
    preload(3'd5, 16'h7FFF);
    issue_op(3'd5, 3'd0, 3'd6, 2'b00, 2'b00, 1'b0, 1'b1, 5'd1, -1, 3'd0, de, nw, wa, bok);
    total++;
    if (rf[6] !== 16'h8000) begin bad++; $display("FAIL ovf_result: got %h want 8000", rf[6]); end
    total++;
    if (status_n !== NV_EN || status_v !== NV_EN || status_z !== 1'b0) begin
      bad++; $display("FAIL ovf_flags: got n=%b v=%b z=%b want %b %b 0", status_n, status_v, status_z, NV_EN, NV_EN);
    end
    model_rf[6] = 16'h8000;
  endtask

  task automatic test_ignore_start;
    int wc0;
    logic [15:0] r7;
    wc0 = write_count;
    r7  = rf[7];
    issue_op(3'd0, 3'd1, 3'd2, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0, 1, 3'd7, de, nw, wa, bok);
    total++;
    if (nw !== 1 || wa !== 3'd2 || write_count - wc0 !== 1) begin
      bad++; $display("FAIL busy_start_wb: got writes=%0d addr=%0d cnt=%0d want 1 2 1", nw, wa, write_count - wc0);
    end
    total++;
    if (rf[7] !== r7 || bok !== 1'b1 || de !== 4) begin
      bad++; $display("FAIL busy_start_ignored: got r7=%h busy_ok=%0d de=%0d want %h 1 4", rf[7], bok, de, r7);
    end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL busy_start_requeue: got busy=%b want 0", busy); end
  endtask

  task automatic test_reset_mid;
    int wc0;
    logic [15:0] r3;
    wc0 = write_count;
    r3  = rf[3];
    @(negedge clk);
    rn_a = 3'd0; rn_b = 3'd1; rd = 3'd3; shift = 2'b00; alu_op = 2'b00;
    asel = 1'b0; bsel = 1'b0; start = 1'b1;
    repeat (3) begin @(posedge clk); @(negedge clk); start = 1'b0; end
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++;
    if ({busy, done, rf_write, status_z, status_n, status_v} !== 6'b0 ||
        {rf_readnum, rf_writenum, rf_data_in} !== 22'd0) begin
      bad++;
      $display("FAIL midreset_outputs: got busy=%b done=%b wr=%b rn=%0d wn=%0d din=%h want all 0",
               busy, done, rf_write, rf_readnum, rf_writenum, rf_data_in);
    end
    reset_n = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    total++;
    if (write_count !== wc0 || rf[3] !== r3) begin
      bad++; $display("FAIL midreset_nowrite: got writes=%0d r3=%h want %0d %h", write_count - wc0, rf[3], 0, r3);
    end
  endtask

  task automatic test_random;
    int c;
    bit z, n, v;
    logic [2:0] ra, rb, rdd;
    logic [1:0] sh, op;
    logic as, bs;
    logic [4:0] im;
    for (int i = 0; i < 8; i++) preload(3'(i), 16'($urandom));
    preload(3'd2, 16'h8000);
    for (int it = 0; it < 40; it++) begin
      ra = 3'($urandom); rb = 3'($urandom); rdd = 3'($urandom);
      sh = 2'($urandom); op = 2'($urandom); im = 5'($urandom);
      as = ($urandom_range(3, 0) == 0); bs = ($urandom_range(3, 0) == 0);
      ref_exec(int'(model_rf[ra]), int'(model_rf[rb]), int'(sh), int'(op),
               int'(as), int'(bs), int'(im), c, z, n, v);
      issue_op(ra, rb, rdd, sh, op, as, bs, im, -1, 3'd0, de, nw, wa, bok);
      model_rf[rdd] = 16'(c);
      total++;
      if (rf[rdd] !== 16'(c) || status_z !== z || de !== 4 || nw !== 1) begin
        bad++;
        $display("FAIL rand_op%0d: got r%0d=%h z=%b de=%0d nw=%0d want %h %b 4 1", it, rdd, rf[rdd], status_z, de, nw, 16'(c), z);
      end
      total++;
      if (status_n !== (n & NV_EN) || status_v !== (v & NV_EN)) begin
        bad++;
        $display("FAIL rand_nv%0d: got n=%b v=%b want %b %b", it, status_n, status_v, n & NV_EN, v & NV_EN);
      end
    end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (rf[i] !== model_rf[i]) begin
        bad++; $display("FAIL rand_regfile r%0d: got %h want %h", i, rf[i], model_rf[i]);
      end
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_sub_shift;
    test_zero_imm;
    test_overflow;
    test_ignore_start;
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
